// File: rtl/weight_addr_pkg.sv
// weight_addr_pkg: shared widths, FSM state type and KKC helper for the weight
// SRAM address generator.
//   DEF_*      default port widths used by weight_addr
//   KKC_W      width of the latched K*K*C row length
//   state_e    controller states
//   calc_kkc   one-time K*K*C product
package weight_addr_pkg;

    localparam int unsigned DEF_KERNEL_SIZE      = 4;
    localparam int unsigned DEF_CHANNELS_SIZE    = 8;
    localparam int unsigned DEF_KERNEL_NUMS_SIZE = 8;
    localparam int unsigned DEF_ADDR_SIZE        = 16;
    localparam int unsigned KKC_W                = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Used once per start; K*K*C always fits 16 bits for the default widths.
    function automatic logic [KKC_W-1:0] calc_kkc(input logic [KKC_W-1:0] k,
                                                 input logic [KKC_W-1:0] c);
        return k * k * c;
    endfunction

endpackage

// File: rtl/weight_addr_cnt.sv
// weight_addr_cnt: nested column (j) / kernel (k) counter pair.
//   clk, rstn        clock, async active-low reset
//   clr              restart at j=0, k=0
//   step             advance: k first, j when k wraps
//   n_last, j_last   last k and last j values of the current job
//   j                current column index
//   k_wrap, j_wrap   k / j sit at their last value
module weight_addr_cnt
    import weight_addr_pkg::*;
#(
    parameter int unsigned JW = 16,
    parameter int unsigned KW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          step,
    input  logic [KW-1:0] n_last,
    input  logic [JW-1:0] j_last,
    output logic [JW-1:0] j,
    output logic          k_wrap,
    output logic          j_wrap
);

    logic [JW-1:0] j_q;
    logic [KW-1:0] k_q;

    assign j      = j_q;
    assign k_wrap = (k_q == n_last);
    assign j_wrap = (j_q == j_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            j_q <= '0;
            k_q <= '0;
        end else if (clr) begin
            j_q <= '0;
            k_q <= '0;
        end else if (step) begin
            if (!k_wrap) begin
                k_q <= k_q + KW'(1);
            end else begin
                k_q <= '0;
                j_q <= j_q + JW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_addr.sv
// weight_addr: weight SRAM address generator for the IMG2COL/GEMM datapath.
// Weights are a row-major N x KKC matrix (KKC = K*K*C); addresses are issued
// column-major (all kernels of column j, then j+1) one per enabled cycle.
//   clk, rstn      clock, async active-low reset
//   enable         run/advance request; dropping it after done returns to idle
//   kernel_size    K, channels C, kernel_nums N (sampled only at start)
//   o_weight_addr  registered address
//   done           registered, sticky until enable drops
module weight_addr
    import weight_addr_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE      = DEF_KERNEL_SIZE,
    parameter int unsigned CHANNELS_SIZE    = DEF_CHANNELS_SIZE,
    parameter int unsigned KERNEL_NUMS_SIZE = DEF_KERNEL_NUMS_SIZE,
    parameter int unsigned ADDR_SIZE        = DEF_ADDR_SIZE
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic [KERNEL_SIZE-1:0]      kernel_size,
    input  logic [CHANNELS_SIZE-1:0]    channels,
    input  logic [KERNEL_NUMS_SIZE-1:0] kernel_nums,
    output logic [ADDR_SIZE-1:0]        o_weight_addr,
    output logic                        done
);

    state_e                      state_q, state_d;
    logic [ADDR_SIZE-1:0]        addr_q, addr_d;
    logic                        done_q, done_d;
    logic [KKC_W-1:0]            kkc_q, kkc_d;
    logic [KKC_W-1:0]            j_last_q, j_last_d;
    logic [KERNEL_NUMS_SIZE-1:0] n_last_q, n_last_d;

    logic                        cnt_clr, cnt_step;
    logic [KKC_W-1:0]            j;
    logic                        k_wrap, j_wrap;
    logic [KKC_W-1:0]            kkc_calc;
    logic                        zero_cfg;

    assign kkc_calc = calc_kkc(KKC_W'(kernel_size), KKC_W'(channels));
    assign zero_cfg = (kernel_size == '0) || (channels == '0) || (kernel_nums == '0);

    weight_addr_cnt #(
        .JW (KKC_W),
        .KW (KERNEL_NUMS_SIZE)
    ) u_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (cnt_clr),
        .step   (cnt_step),
        .n_last (n_last_q),
        .j_last (j_last_q),
        .j      (j),
        .k_wrap (k_wrap),
        .j_wrap (j_wrap)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = done_q;
        kkc_d    = kkc_q;
        j_last_d = j_last_q;
        n_last_d = n_last_q;
        cnt_clr  = 1'b0;
        cnt_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                done_d = 1'b0;
                if (enable) begin
                    kkc_d    = kkc_calc;
                    j_last_d = kkc_calc - KKC_W'(1);
                    n_last_d = kernel_nums - KERNEL_NUMS_SIZE'(1);
                    if (zero_cfg) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        // Address 0 is presented from this start edge.
                        state_d = StRun;
                        cnt_clr = 1'b1;
                    end
                end
            end
            StRun: begin
                if (enable) begin
                    if (!k_wrap) begin
                        // Next kernel, same column: one row further down.
                        addr_d   = addr_q + ADDR_SIZE'(kkc_q);
                        cnt_step = 1'b1;
                    end else if (!j_wrap) begin
                        // Back to kernel 0 of the next column.
                        addr_d   = ADDR_SIZE'(j) + ADDR_SIZE'(1);
                        cnt_step = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            done_q   <= 1'b0;
            kkc_q    <= '0;
            j_last_q <= '0;
            n_last_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            kkc_q    <= kkc_d;
            j_last_q <= j_last_d;
            n_last_q <= n_last_d;
        end
    end

    assign o_weight_addr = addr_q;
    assign done          = done_q;

endmodule

// File: tb/tb_weight_addr.sv
// tb_weight_addr: directed test of weight_addr. Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the edge.
module tb_weight_addr;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [3:0]  kernel_size;
    logic [7:0]  channels;
    logic [7:0]  kernel_nums;
    logic [15:0] o_weight_addr;
    logic        done;

    int vectors;
    int miscompares;

    weight_addr dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .kernel_size   (kernel_size),
        .channels      (channels),
        .kernel_nums   (kernel_nums),
        .o_weight_addr (o_weight_addr),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // i-th address in feed order: kernel k = i % n, column j = i / n.
    function automatic int exp_addr(input int i, input int n, input int kkc);
        return (i % n) * kkc + (i / n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        enable      = 1'b0;
        kernel_size = 4'd2;
        channels    = 8'd3;
        kernel_nums = 8'd10;

        // Reset state
        #12;
        chk("reset_addr", 32'(o_weight_addr), 0);
        chk("reset_done", 32'(done), 0);
        #8 rstn = 1'b1;
        #18 enable = 1'b1;

        // Run 1: K=2 C=3 N=10, KKC=12, 120 addresses
        for (int i = 0; i < 120; i++) begin
            tick();
            chk("run1_addr", 32'(o_weight_addr), 32'(exp_addr(i, 10, 12)));
            chk("run1_done", 32'(done), 0);
        end
        tick();
        chk("run1_done_rise", 32'(done), 1);
        chk("run1_addr_hold", 32'(o_weight_addr), 119);
        tick();
        chk("run1_done_sticky", 32'(done), 1);
        chk("run1_addr_sticky", 32'(o_weight_addr), 119);

        // Drop enable: back to idle
        enable = 1'b0;
        tick();
        chk("idle1_done", 32'(done), 0);
        chk("idle1_addr", 32'(o_weight_addr), 0);
        tick();
        chk("idle1_hold", 32'(o_weight_addr), 0);

        // Run 2: same config with a 3-cycle pause and config changes mid-run
        enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            chk("run2_addr", 32'(o_weight_addr), 32'(exp_addr(i, 10, 12)));
            chk("run2_done", 32'(done), 0);
            if (i == 30) begin
                enable = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    tick();
                    chk("pause_addr", 32'(o_weight_addr), 32'(exp_addr(30, 10, 12)));
                    chk("pause_done", 32'(done), 0);
                end
                enable = 1'b1;
            end
            if (i == 50) begin
                kernel_nums = 8'd3;
                channels    = 8'd1;
            end
        end
        tick();
        chk("run2_done_rise", 32'(done), 1);
        chk("run2_addr_hold", 32'(o_weight_addr), 119);

        // Run 3: K=1 C=1 N=3 -> 0,1,2
        enable = 1'b0;
        tick();
        chk("idle2_done", 32'(done), 0);
        kernel_size = 4'd1;
        channels    = 8'd1;
        kernel_nums = 8'd3;
        enable      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run3_addr", 32'(o_weight_addr), 32'(i));
            chk("run3_done", 32'(done), 0);
        end
        tick();
        chk("run3_done_rise", 32'(done), 1);
        chk("run3_addr_hold", 32'(o_weight_addr), 2);

        // Run 4: K=3 C=2 N=4, KKC=18, 72 addresses
        enable = 1'b0;
        tick();
        kernel_size = 4'd3;
        channels    = 8'd2;
        kernel_nums = 8'd4;
        enable      = 1'b1;
        for (int i = 0; i < 72; i++) begin
            tick();
            chk("run4_addr", 32'(o_weight_addr), 32'(exp_addr(i, 4, 18)));
        end
        tick();
        chk("run4_done_rise", 32'(done), 1);
        chk("run4_addr_hold", 32'(o_weight_addr), 71);

        // Zero configs: N=0, C=0, K=0 each finish on the first enabled edge
        for (int z = 0; z < 3; z++) begin
            enable = 1'b0;
            tick();
            chk("zero_idle_done", 32'(done), 0);
            kernel_size = (z == 2) ? 4'd0 : 4'd2;
            channels    = (z == 1) ? 8'd0 : 8'd3;
            kernel_nums = (z == 0) ? 8'd0 : 8'd10;
            enable      = 1'b1;
            tick();
            chk("zero_done", 32'(done), 1);
            chk("zero_addr", 32'(o_weight_addr), 0);
            tick();
            chk("zero_done_sticky", 32'(done), 1);
        end

        // Async reset mid-run
        enable = 1'b0;
        tick();
        kernel_size = 4'd2;
        channels    = 8'd3;
        kernel_nums = 8'd10;
        enable      = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("pre_rst_addr", 32'(o_weight_addr), 32'(exp_addr(14, 10, 12)));
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_addr", 32'(o_weight_addr), 0);
        chk("async_rst_done", 32'(done), 0);
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("restart_addr", 32'(o_weight_addr), 32'(exp_addr(i, 10, 12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
